// File: rtl/ftq_commit_queue_pkg.sv
// ftq_commit_queue_pkg: core configuration and shared types for the fetch target queue.
// FTQ_PERF_COUNTER_EN (optional macro, consumed by the top) enables the perf counters.
package ftq_commit_queue_pkg;

  // core_config
  localparam int unsigned FRONTEND_FTQ_SIZE = 8;
  localparam int unsigned COMMIT_WIDTH      = 2;
  localparam int unsigned FTQ_PC_WIDTH      = 32;
  localparam int unsigned FTQ_IDX_WIDTH     = $clog2(FRONTEND_FTQ_SIZE);

  // core_types
  typedef struct packed {
    logic [FTQ_PC_WIDTH-1:0] start_pc;
    logic [2:0]              length;
  } ftq_entry_t;

  typedef struct packed {
    logic                     wrap;
    logic [FTQ_IDX_WIDTH-1:0] idx;
  } ftq_ptr_t;

endpackage

// File: rtl/ftq_commit_queue_entry_ram.sv
// ftq_entry_ram: FTQ entry storage, one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module ftq_entry_ram
  import ftq_commit_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = FRONTEND_FTQ_SIZE,
  parameter type         entry_t = ftq_entry_t
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  entry_t                   i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output entry_t                   o_rdata
);

  entry_t r_mem [DEPTH];

  // write the pushed block into its slot
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ftq_commit_queue.sv
// ftq_commit_queue: fetch target queue with in-order IFU hand-off and backend commit/flush.
// Optional macro FTQ_PERF_COUNTER_EN adds saturating commit/flush counters.
module ftq_commit_queue
  import ftq_commit_queue_pkg::*;
#(
  parameter int unsigned FTQ_SIZE     = FRONTEND_FTQ_SIZE,
  parameter int unsigned COMMIT_WIDTH = ftq_commit_queue_pkg::COMMIT_WIDTH,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bpu_valid_i,
  input  logic [ADDR_WIDTH-1:0]        bpu_start_pc_i,
  input  logic [2:0]                   bpu_length_i,
  output logic                         bpu_ready_o,
  output logic                         ifu_valid_o,
  output logic [ADDR_WIDTH-1:0]        ifu_start_pc_o,
  output logic [2:0]                   ifu_length_o,
  output logic [$clog2(FTQ_SIZE)-1:0]  ifu_ftq_id_o,
  input  logic                         ifu_accept_i,
  input  logic [COMMIT_WIDTH-1:0]      backend_commit_block_i,
  input  logic                         backend_flush_i,
  input  logic [$clog2(FTQ_SIZE)-1:0]  backend_flush_ftq_id_i,
  output logic                         bpu_flush_o,
  output logic [$clog2(FTQ_SIZE):0]    ftq_count_o,
  output logic                         commit_overrun_o,
  output logic [31:0]                  perf_commit_cnt_o,
  output logic [31:0]                  perf_flush_cnt_o
);

  localparam int unsigned IDX_W = $clog2(FTQ_SIZE);
  localparam int unsigned PW    = IDX_W + 1;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] start_pc;
    logic [2:0]            length;
  } entry_t;

  ptr_t             r_comm_ptr, r_ifu_ptr, r_bpu_ptr;
  logic             r_bpu_flush, r_overrun;

  logic             w_full, w_push, w_ifu_valid, w_accept, w_overrun_now, w_flush_empty;
  logic [PW-1:0]    w_commit_n, w_ci_dist;
  logic [IDX_W-1:0] w_flush_idx;
  ptr_t             w_comm_nxt, w_flush_ptr;
  entry_t           w_wdata, w_rdata;

  assign w_full      = (r_comm_ptr.idx == r_bpu_ptr.idx) && (r_comm_ptr.wrap != r_bpu_ptr.wrap);
  assign w_ifu_valid = (r_ifu_ptr != r_bpu_ptr);
  assign w_push      = bpu_valid_i & ~w_full & ~backend_flush_i;
  assign w_accept    = ifu_accept_i & w_ifu_valid & ~backend_flush_i;

  assign w_wdata.start_pc = bpu_start_pc_i & ~ADDR_WIDTH'(3);
  assign w_wdata.length   = bpu_length_i;

  // commit advance with clamp at ifu_ptr, then flush pointer from the post-commit comm_ptr
  always_comb begin
    w_commit_n = '0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++)
      w_commit_n = w_commit_n + PW'(backend_commit_block_i[i]);
    w_ci_dist     = r_ifu_ptr - r_comm_ptr;
    w_overrun_now = (w_commit_n > w_ci_dist);
    w_comm_nxt    = w_overrun_now ? r_ifu_ptr : ptr_t'(r_comm_ptr + w_commit_n);
    // the flushed index equal to comm_ptr means nothing survives: keep the wrap bit
    w_flush_idx       = backend_flush_ftq_id_i + 1'b1;
    w_flush_empty     = (w_flush_idx == w_comm_nxt.idx);
    w_flush_ptr.idx   = w_flush_idx;
    w_flush_ptr.wrap  = w_comm_nxt.wrap ^ ((w_flush_idx <= w_comm_nxt.idx) & ~w_flush_empty);
  end

  // pointer, flush pulse and sticky overrun state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_comm_ptr  <= '0;
      r_ifu_ptr   <= '0;
      r_bpu_ptr   <= '0;
      r_bpu_flush <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_comm_ptr  <= w_comm_nxt;
      r_bpu_flush <= backend_flush_i;
      if (w_overrun_now) r_overrun <= 1'b1;
      if (backend_flush_i) begin
        r_bpu_ptr <= w_flush_ptr;
        r_ifu_ptr <= w_flush_ptr;
      end else begin
        if (w_push)   r_bpu_ptr <= r_bpu_ptr + 1'b1;
        if (w_accept) r_ifu_ptr <= r_ifu_ptr + 1'b1;
      end
    end
  end

  ftq_entry_ram #(
    .DEPTH   (FTQ_SIZE),
    .entry_t (entry_t)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_bpu_ptr.idx),
    .i_wdata (w_wdata),
    .i_raddr (r_ifu_ptr.idx),
    .o_rdata (w_rdata)
  );

  assign bpu_ready_o      = ~w_full;
  assign ifu_valid_o      = w_ifu_valid;
  assign ifu_start_pc_o   = w_rdata.start_pc;
  assign ifu_length_o     = w_rdata.length;
  assign ifu_ftq_id_o     = r_ifu_ptr.idx;
  assign bpu_flush_o      = r_bpu_flush;
  assign ftq_count_o      = r_bpu_ptr - r_comm_ptr;
  assign commit_overrun_o = r_overrun;

`ifdef FTQ_PERF_COUNTER_EN
  logic [31:0] r_perf_commit, r_perf_flush;

  // saturating commit and flush event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_commit <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (r_perf_commit > (32'hFFFF_FFFF - 32'(w_commit_n))) r_perf_commit <= '1;
      else r_perf_commit <= r_perf_commit + 32'(w_commit_n);
      if (backend_flush_i && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign perf_commit_cnt_o = r_perf_commit;
  assign perf_flush_cnt_o  = r_perf_flush;
`else
  assign perf_commit_cnt_o = '0;
  assign perf_flush_cnt_o  = '0;
`endif

endmodule

// File: doc/ftq_commit_queue.md
# ftq_commit_queue

Fetch Target Queue in the frontend: buffers basic blocks predicted by the BPU, hands them in order to the IFU, and retires or discards them according to the backend's per-cycle commit mask and flush FTQ ID. It is the receiving end of the backend commit interface: `backend_commit_block` and `backend_flush_ftq_id`. Every FTQ ID carried down the pipeline originates here.

## Interface
Parameters:
- FTQ_SIZE, FRONTEND_FTQ_SIZE (8): entry count; must be a power of two ≥ 4.
- COMMIT_WIDTH, COMMIT_WIDTH (2): backend commit lanes.
- ADDR_WIDTH, 32: PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- bpu_valid_i  in  1  BPU offers a block.
- bpu_start_pc_i  in  ADDR_WIDTH  block start PC, low 2 bits ignored.
- bpu_length_i  in  3  instructions in block, 1..4.
- bpu_ready_o  out  1  queue not full.
- ifu_valid_o  out  1  an unsent entry exists.
- ifu_start_pc_o  out  ADDR_WIDTH  PC of the entry at ifu_ptr.
- ifu_length_o  out  3  length of the entry at ifu_ptr.
- ifu_ftq_id_o  out  $clog2(FTQ_SIZE)  ID of the entry at ifu_ptr.
- ifu_accept_i  in  1  IFU takes the entry.
- backend_commit_block_i  in  COMMIT_WIDTH  per-lane "basic block completed".
- backend_flush_i  in  1  backend flush; the backend ORs excp, ertn and idle into this signal.
- backend_flush_ftq_id_i  in  $clog2(FTQ_SIZE)  ID of the last surviving block.
- bpu_flush_o  out  1  registered pulse telling the BPU to restart.
- ftq_count_o  out  $clog2(FTQ_SIZE)+1  number of occupied entries.
- commit_overrun_o  out  1  sticky error: a commit went past ifu_ptr.

## Operation
- Three pointers, each an index plus a wrap bit: `comm_ptr`, `ifu_ptr`, `bpu_ptr`. Ordering invariant: comm ≤ ifu ≤ bpu.
- Empty: `comm_ptr == bpu_ptr`. Full: the indices are equal and the wrap bits differ.
- `bpu_ready_o = !full`, computed from registered state only. A commit in the same cycle does not free a slot for a push in that cycle.
- Push: on `bpu_valid_i & bpu_ready_o`, write {pc, length} at `bpu_ptr`, then increment `bpu_ptr`.
- IFU port:
  - `ifu_valid_o = (ifu_ptr != bpu_ptr)`.
  - Data is read combinationally from the entry at `ifu_ptr`.
  - `ifu_accept_i & ifu_valid_o` increments `ifu_ptr`.
  - `ifu_accept_i` while invalid is ignored.
- Commit: `comm_ptr` advances by popcount(`backend_commit_block_i`), i.e. 0, 1 or 2.
  - If the advance would pass `ifu_ptr`, clamp `comm_ptr` to `ifu_ptr` and set `commit_overrun_o`.
  - `commit_overrun_o` is cleared only by reset.
- Flush: `bpu_ptr` and `ifu_ptr` are both set to flush_id+1, modulo FTQ_SIZE.
  - Wrap bit = post-commit `comm_ptr.wrap`, XOR 1 if the new index is ≤ the post-commit `comm_ptr` index and the queue is not empty after the flush.
  - Flush takes priority over a push and an IFU accept in the same cycle; both are dropped.
- Same-cycle commit + flush: apply the commit first, then the flush. The flushed block itself is committed in the same cycle, so the queue is empty after that cycle when the flush ID equals the last committed ID.
- `bpu_flush_o` is asserted in the cycle after `backend_flush_i`.
- `ftq_count_o = bpu_ptr - comm_ptr`, using the wrap bit in the subtraction.
- Reset values:
  - All pointers 0.
  - `bpu_ready_o` = 1.
  - `ifu_valid_o`, `bpu_flush_o`, `commit_overrun_o` = 0.
  - `ftq_count_o` = 0.
  - Entry storage is not reset.

## Timing
- Push to visibility on the IFU port: one cycle.
- Commit frees a slot: `bpu_ready_o` rises in the next cycle.
- Flush: pointers update at the edge; `ifu_valid_o` reflects the flush in the next cycle; `bpu_flush_o` is high for exactly one cycle.
- Reset asserted mid-operation clears all state at the next edge regardless of other inputs.

## Configuration
- `FTQ_PERF_COUNTER_EN` defined:
  - Adds outputs `perf_commit_cnt_o` [31:0] (sum of commit popcounts) and `perf_flush_cnt_o` [31:0] (flush count).
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Macro undefined: both ports still exist, are tied to 0, and the counters are not instantiated.

## Structure
- `core_config`: FRONTEND_FTQ_SIZE, COMMIT_WIDTH.
- `core_types`: `ftq_entry_t` {start_pc, length}, `ftq_ptr_t` {wrap, idx}.
- Sub-module `ftq_entry_ram`: one write port, one async read port, FTQ_SIZE × `ftq_entry_t`.
- Pointer arithmetic stays in the top module.

## Test plan
- Fill: 8 pushes, no accepts -> `bpu_ready_o` = 0 after the 8th, `ftq_count_o` = 8. A 9th push is refused.
- Stream: push PC 0x1c000000..0x1c00001c, accept each -> `ifu_ftq_id_o` = 0..7, PCs in order.
- Dual commit: 4 entries accepted, commit 2'b11 -> `ftq_count_o` 4→2, `comm_ptr` = 2.
- Flush: entries 0..5 sent, `backend_flush_i` with ID 2 plus commit 2'b01 at comm = 2 -> `bpu_ptr` = `ifu_ptr` = 3, count 0, `bpu_flush_o` high one cycle later.
- Wrap: 20 push/accept/commit rounds, then flush with ID 1 -> wrap bits correct, next `ifu_ftq_id_o` = 2.
- Overrun: commit 2'b11 with a single accepted entry -> `comm_ptr` = `ifu_ptr`, `commit_overrun_o` sticky 1 until rst = 0.
